// File: rtl/if_id_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : if_id_pkg                                                    |
// | Description : Shared datapath defaults for the pipeline registers.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package if_id_pkg;

  localparam int unsigned        C_DATA_W   = 16;
  localparam logic [C_DATA_W-1:0] C_NOP_INST = 16'h0000;

endpackage : if_id_pkg

`default_nettype wire

// File: rtl/pipe_reg.sv
// +----------------------------------------------------------------------------+
// | Module      : pipe_reg                                                     |
// | Description : Pipeline register, async active-low reset, sync clear, en.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_reg #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear outranks enable so a squash wins over a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : pipe_reg

`default_nettype wire

// File: rtl/if_id.sv
// +----------------------------------------------------------------------------+
// | Module      : if_id                                                        |
// | Description : IF/ID pipeline register with flush and stall.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_id
  import if_id_pkg::*;
#(
  parameter int unsigned       DATA_W   = C_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(C_NOP_INST)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              IFIDWrite,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] PC_Plus2,
  output logic [DATA_W-1:0] instReg,
  output logic [DATA_W-1:0] PC_Plus2Reg
);

  // Both fields share clear and enable so they always move together.
  pipe_reg #(
    .WIDTH   (DATA_W),
    .RST_VAL (NOP_INST),
    .CLR_VAL (NOP_INST)
  ) u_inst_reg (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (flush),
    .i_en  (IFIDWrite),
    .i_d   (inst),
    .o_q   (instReg)
  );

  pipe_reg #(
    .WIDTH   (DATA_W),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (flush),
    .i_en  (IFIDWrite),
    .i_d   (PC_Plus2),
    .o_q   (PC_Plus2Reg)
  );

endmodule : if_id

`default_nettype wire

// File: tb/tb_if_id.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_if_id                                                     |
// | Description : Self-checking bench for if_id against a behavioural model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_id;

  localparam int unsigned C_W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic           IFIDWrite;
  logic [C_W-1:0] inst;
  logic [C_W-1:0] PC_Plus2;
  logic [C_W-1:0] instReg;
  logic [C_W-1:0] PC_Plus2Reg;

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 1'b1;

  logic [C_W-1:0] exp_inst = '0;
  logic [C_W-1:0] exp_pc   = '0;

  if_id dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .IFIDWrite   (IFIDWrite),
    .inst        (inst),
    .PC_Plus2    (PC_Plus2),
    .instReg     (instReg),
    .PC_Plus2Reg (PC_Plus2Reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [C_W-1:0] act, input logic [C_W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  // Reference: what the IF/ID pair must hold, by the priority reset > flush > write.
  always @(posedge clk or negedge reset) begin
    if (reset !== 1'b1) begin
      exp_inst <= 16'h0000;
      exp_pc   <= 16'h0000;
    end else if (flush) begin
      exp_inst <= 16'h0000;
      exp_pc   <= 16'h0000;
    end else if (IFIDWrite) begin
      exp_inst <= inst;
      exp_pc   <= PC_Plus2;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_inst", instReg, exp_inst);
      check("model_pc", PC_Plus2Reg, exp_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic [C_W-1:0] ei, input logic [C_W-1:0] ep);
    check({name, "_inst"}, instReg, ei);
    check({name, "_pc"}, PC_Plus2Reg, ep);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; IFIDWrite = 1'b1;
    inst = 16'h0A0A; PC_Plus2 = 16'h2222;

    // Held in reset with clocks running.
    repeat (3) begin
      step();
      expect_lit("reset_hold", 16'h0000, 16'h0000);
    end

    reset = 1'b1;
    step();
    expect_lit("first_load", 16'h0A0A, 16'h2222);

    inst = 16'h1111; PC_Plus2 = 16'hFFFF;
    step();
    expect_lit("second_load", 16'h1111, 16'hFFFF);

    IFIDWrite = 1'b0; inst = 16'h2345; PC_Plus2 = 16'hBEEF;
    repeat (3) begin
      step();
      expect_lit("stall", 16'h1111, 16'hFFFF);
    end

    IFIDWrite = 1'b1; flush = 1'b1; inst = 16'h1111; PC_Plus2 = 16'hFFFF;
    step();
    expect_lit("flush_wr1", 16'h0000, 16'h0000);

    flush = 1'b0;
    step();
    expect_lit("reload", 16'h1111, 16'hFFFF);

    flush = 1'b1; IFIDWrite = 1'b0;
    step();
    expect_lit("flush_wr0", 16'h0000, 16'h0000);

    // Mid-cycle input wiggle must not reach the outputs.
    flush = 1'b0; IFIDWrite = 1'b1; inst = 16'hABCD; PC_Plus2 = 16'h1234;
    step();
    inst = 16'h5555; PC_Plus2 = 16'h6666;
    #2;
    expect_lit("between_edges", 16'hABCD, 16'h1234);

    inst = 16'h1111; PC_Plus2 = 16'hFFFF;
    step();
    expect_lit("pre_pulse", 16'h1111, 16'hFFFF);

    // Asynchronous reset pulse well before the next clock edge.
    IFIDWrite = 1'b1; flush = 1'b1;
    reset = 1'b0;
    #1;
    expect_lit("async_reset", 16'h0000, 16'h0000);
    reset = 1'b1; flush = 1'b0; IFIDWrite = 1'b0;
    step();
    expect_lit("post_reset_stall", 16'h0000, 16'h0000);

    IFIDWrite = 1'b1; inst = 16'h8001; PC_Plus2 = 16'h7FFE;
    step();
    expect_lit("post_reset_load", 16'h8001, 16'h7FFE);

    // Mixed traffic checked only by the model.
    for (int i = 0; i < 40; i++) begin
      flush     = ($urandom_range(0, 4) == 0);
      IFIDWrite = ($urandom_range(0, 3) != 0);
      inst      = 16'($urandom);
      PC_Plus2  = 16'($urandom);
      step();
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_if_id

`default_nettype wire

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 The module SHALL take parameter DATA_W, default 16, as the width of the instruction and PC+2 paths.
REQ-002 The module SHALL take parameter NOP_INST, default 16'h0000, as the value loaded into instReg on flush.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port flush, input, 1 bit: squash the IF/ID contents, e.g. on a taken branch.
REQ-006 The module SHALL have port IFIDWrite, input, 1 bit: load enable; 0 stalls the register.
REQ-007 The module SHALL have port inst, input, DATA_W bits: instruction fetched in IF.
REQ-008 The module SHALL have port PC_Plus2, input, DATA_W bits: fetch PC + 2 from IF.
REQ-009 The module SHALL have port instReg, output, DATA_W bits: registered instruction presented to ID.
REQ-010 The module SHALL have port PC_Plus2Reg, output, DATA_W bits: registered PC + 2 presented to ID.

Function
REQ-011 Outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-012 Priority at each rising clk edge SHALL be: reset low, then flush, then IFIDWrite.
REQ-013 When flush=1 at a rising edge, instReg SHALL load NOP_INST and PC_Plus2Reg SHALL load 0, regardless of IFIDWrite.
REQ-014 When flush=0 and IFIDWrite=1 at a rising edge, instReg SHALL load inst and PC_Plus2Reg SHALL load PC_Plus2.
REQ-015 When flush=0 and IFIDWrite=0 at a rising edge, both outputs SHALL hold their previous values (stall).
REQ-016 Latency from input to output SHALL be exactly one clock edge.
REQ-017 Input changes between edges SHALL have no effect on the outputs.
REQ-018 Both output fields SHALL always update together, never independently.
REQ-019 Width handling SHALL be a straight copy, with no arithmetic, truncation or sign extension.

Reset
REQ-020 While reset=0, instReg SHALL be NOP_INST and PC_Plus2Reg SHALL be 0, asynchronously and independent of clk.
REQ-021 Reset assertion mid-operation SHALL clear both outputs immediately, overriding flush and IFIDWrite.
REQ-022 After reset deasserts, the first rising edge SHALL apply REQ-013 to REQ-015 normally.

Structure
REQ-023 DATA_W and NOP_INST defaults SHALL live in the shared datapath package used by all pipeline registers.
REQ-024 One sub-module, pipe_reg, SHALL be used: a DATA_W register with async active-low reset, synchronous clear and enable.
REQ-025 if_id SHALL instantiate pipe_reg twice, once for the instruction and once for PC+2.

Verification
REQ-026 Reset held low, inst=0A0A, PC_Plus2=2222, IFIDWrite=1, clocks running -> outputs remain 0000/0000.
REQ-027 Reset released, IFIDWrite=1, flush=0, inst=0A0A, PC_Plus2=2222 -> after the next edge instReg=0A0A and PC_Plus2Reg=2222.
REQ-028 Inputs changed to inst=1111, PC_Plus2=FFFF with IFIDWrite=1 -> after the next edge instReg=1111 and PC_Plus2Reg=FFFF.
REQ-029 IFIDWrite=0 with inputs changed to 2345/BEEF for 3 edges -> outputs hold 1111/FFFF.
REQ-030 flush=1, IFIDWrite=1, inst=1111, PC_Plus2=FFFF -> after the next edge outputs are 0000/0000; flush=1 with IFIDWrite=0 gives the same result.
REQ-031 Reset pulsed low between edges while outputs are 1111/FFFF -> outputs go to 0000/0000 immediately, with no clk edge required.
